pixel_scan_gen: RTL and testbench

- Parametrised, handshaked successor to the pixel position walker.
- Generates the (x, y) pixel coordinates a FAST detection pass visits over an image of runtime-configured size.
- Supports raster or serpentine order and a runtime border margin, so corner tests never reach off-image pixels.
- Sits between the frame controller (start/config) and the window fetch/compare pipeline (valid/ready consumer).

---
 rtl/pixel_scan_gen.sv | 151 +++++++++++++++
 tb/tb_pixel_scan_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scan_gen.sv
// rtl/pixel_scan_gen.sv - handshaked raster/serpentine pixel coordinate generator
module pixel_scan_gen #(
  parameter int X_MAX = 300,
  parameter int Y_MAX = 300,
  parameter int BW    = 4,
  parameter int XW    = $clog2(X_MAX + 1),
  parameter int YW    = $clog2(Y_MAX + 1),
  parameter int CW    = $clog2(X_MAX * Y_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [XW-1:0] max_x,
  input  logic [YW-1:0] max_y,
  input  logic [BW-1:0] border,
  input  logic          pos_ready,
  output logic          pos_valid,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y,
  output logic [1:0]    next_dir,
  output logic          row_start,
  output logic          row_end,
  output logic          frame_end,
  output logic [CW-1:0] pos_idx,
  output logic          busy,
  output logic          done,
  output logic          cfg_err
);

  localparam int XE = XW + BW + 1;
  localparam int YE = YW + BW + 1;
  localparam logic [XW-1:0] X_LIM = XW'(X_MAX);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          mode_r;
  logic          dir_left;
  logic          cfg_seen;
  logic [XW-1:0] x_lo;
  logic [XW-1:0] x_hi;
  logic [YW-1:0] y_hi;
  logic          cfg_ok;
  logic          accept;
  logic [XE-1:0] mx_ext;
  logic [XE-1:0] bx2;
  logic [YE-1:0] my_ext;
  logic [YE-1:0] by2;

  always_comb begin
    mx_ext = XE'(max_x);
    bx2    = XE'(border) << 1;
    my_ext = YE'(max_y);
    by2    = YE'(border) << 1;
    cfg_ok = (max_x != '0) && (max_x <= X_LIM) &&
             (max_y != '0) && (max_y <= Y_LIM) &&
             (mx_ext > bx2) && (my_ext > by2);
  end

  assign accept = (state == S_SCAN) && pos_ready && !start;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // A start from any state restarts the scan; it takes priority over an accept.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = cfg_ok ? S_SCAN : S_IDLE;
    end else begin
      case (state)
        S_SCAN:  if (accept && frame_end) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    row_start = 1'b0;
    row_end   = 1'b0;
    frame_end = 1'b0;
    next_dir  = 2'b00;
    if (state == S_SCAN) begin
      row_end   = dir_left ? (curr_x == x_lo) : (curr_x == x_hi);
      row_start = dir_left ? (curr_x == x_hi) : (curr_x == x_lo);
      frame_end = row_end && (curr_y == y_hi);
      if (frame_end)    next_dir = 2'b11;
      else if (row_end) next_dir = 2'b10;
      else              next_dir = {1'b0, dir_left};
    end else if (cfg_seen) begin
      // Only a freshly reset block reports 00 while not scanning.
      next_dir = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_seen  <= 1'b0;
      mode_r    <= 1'b0;
      dir_left  <= 1'b0;
      x_lo      <= '0;
      x_hi      <= '0;
      y_hi      <= '0;
      curr_x    <= '0;
      curr_y    <= '0;
      pos_idx   <= '0;
    end else begin
      pos_valid <= (state_nxt == S_SCAN);
      busy      <= (state_nxt == S_SCAN);
      done      <= (state_nxt == S_DONE);
      cfg_err   <= start && !cfg_ok;
      if (start) begin
        cfg_seen <= 1'b1;
        if (cfg_ok) begin
          mode_r   <= mode;
          dir_left <= 1'b0;
          x_lo     <= XW'(border);
          x_hi     <= max_x - XW'(1) - XW'(border);
          y_hi     <= max_y - YW'(1) - YW'(border);
          curr_x   <= XW'(border);
          curr_y   <= YW'(border);
          pos_idx  <= '0;
        end
      end else if (accept) begin
        pos_idx <= pos_idx + CW'(1);
        if (!row_end) begin
          curr_x <= dir_left ? curr_x - XW'(1) : curr_x + XW'(1);
        end else if (!frame_end) begin
          curr_y <= curr_y + YW'(1);
          if (mode_r) dir_left <= !dir_left;
          else        curr_x   <= x_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_scan_gen.sv
// tb/tb_pixel_scan_gen.sv - randomized self-checking bench for pixel_scan_gen
module tb_pixel_scan_gen;

  localparam int X_MAX = 300;
  localparam int Y_MAX = 300;
  localparam int XW = $clog2(X_MAX + 1);
  localparam int YW = $clog2(Y_MAX + 1);
  localparam int CW = $clog2(X_MAX * Y_MAX + 1);
  localparam int SCAN_LIMIT = 6000;

  logic          clk;
  logic          rst;
  logic          start;
  logic          mode;
  logic [XW-1:0] max_x;
  logic [YW-1:0] max_y;
  logic [3:0]    border;
  logic          pos_ready;
  logic          pos_valid;
  logic [XW-1:0] curr_x;
  logic [YW-1:0] curr_y;
  logic [1:0]    next_dir;
  logic          row_start;
  logic          row_end;
  logic          frame_end;
  logic [CW-1:0] pos_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_scan_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .max_x(max_x), .max_y(max_y), .border(border), .pos_ready(pos_ready),
    .pos_valid(pos_valid), .curr_x(curr_x), .curr_y(curr_y), .next_dir(next_dir),
    .row_start(row_start), .row_end(row_end), .frame_end(frame_end),
    .pos_idx(pos_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cfg_valid(input int mx, input int my, input int b);
    return mx >= 1 && mx <= X_MAX && my >= 1 && my <= Y_MAX && mx > 2 * b && my > 2 * b;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, pos_valid, 0);
    check({tag, "_x"}, curr_x, 0);
    check({tag, "_y"}, curr_y, 0);
    check({tag, "_idx"}, pos_idx, 0);
    check({tag, "_dir"}, next_dir, 0);
    check({tag, "_flags"}, {row_start, row_end, frame_end}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  // Config inputs are scrambled after the start pulse; the DUT must use its latched copy.
  task automatic do_start(input bit md, input int mx, input int my, input int b);
    mode  = md;
    max_x = XW'(mx);
    max_y = YW'(my);
    border = 4'(b);
    start = 1'b1;
    tick();
    start  = 1'b0;
    mode   = 1'($urandom);
    max_x  = XW'($urandom);
    max_y  = YW'($urandom);
    border = 4'($urandom);
  endtask

  // pct < 0 means ready every fifth cycle; stop_idx >= 0 leaves the scan running there.
  task automatic follow(input bit md, input int mx, input int my, input int b,
                        input int pct, input int stop_idx);
    int ex[$]; int ey[$]; int ers[$]; int ere[$]; int efe[$]; int end_dir[$];
    int w, h, n, i, cyc;
    bit r;
    w = mx - 2 * b;
    h = my - 2 * b;
    for (int row = 0; row < h; row++) begin
      for (int k = 0; k < w; k++) begin
        bit rev;
        rev = md && (row % 2 == 1);
        ex.push_back(rev ? (mx - 1 - b - k) : (b + k));
        ey.push_back(b + row);
        ers.push_back(k == 0);
        ere.push_back(k == w - 1);
        efe.push_back(row == h - 1 && k == w - 1);
        if (row == h - 1 && k == w - 1) end_dir.push_back(3);
        else if (k == w - 1)            end_dir.push_back(2);
        else                            end_dir.push_back(rev ? 1 : 0);
      end
    end
    n = ex.size();
    i = 0;
    cyc = 0;
    while (i < n && cyc < SCAN_LIMIT) begin
      check($sformatf("valid[%0d]", i), pos_valid, 1);
      check($sformatf("busy[%0d]", i), busy, 1);
      check($sformatf("done[%0d]", i), done, 0);
      check($sformatf("x[%0d]", i), curr_x, ex[i]);
      check($sformatf("y[%0d]", i), curr_y, ey[i]);
      check($sformatf("idx[%0d]", i), pos_idx, i);
      check($sformatf("rs[%0d]", i), row_start, ers[i]);
      check($sformatf("re[%0d]", i), row_end, ere[i]);
      check($sformatf("fe[%0d]", i), frame_end, efe[i]);
      check($sformatf("dir[%0d]", i), next_dir, end_dir[i]);
      if (i == stop_idx) return;
      r = (pct < 0) ? (cyc % 5 == 4) : ($urandom_range(99) < pct);
      pos_ready = r;
      tick();
      if (r) i++;
      cyc++;
    end
    pos_ready = 1'b0;
    check("scan_budget", i, n);
    check("end_done", done, 1);
    check("end_valid", pos_valid, 0);
    check("end_busy", busy, 0);
    check("end_dir", next_dir, 3);
    check("end_x", curr_x, ex[n-1]);
    check("end_y", curr_y, ey[n-1]);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic try_start(input int mx, input int my, input int b);
    bit ok;
    ok = cfg_valid(mx, my, b);
    do_start(1'($urandom), mx, my, b);
    check($sformatf("cfg_err_%0dx%0db%0d", mx, my, b), cfg_err, !ok);
    check("cfg_busy", busy, ok);
    check("cfg_valid", pos_valid, ok);
    tick();
    check("cfg_err_clear", cfg_err, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; max_x = '0; max_y = '0;
    border = '0; pos_ready = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("post_reset");

    do_start(1'b0, 5, 5, 0);
    follow(1'b0, 5, 5, 0, 100, -1);

    do_start(1'b1, 5, 5, 0);
    follow(1'b1, 5, 5, 0, -1, -1);

    do_start(1'b1, 10, 10, 3);
    follow(1'b1, 10, 10, 3, 60, -1);

    try_start(6, 6, 3);
    check("bad_cfg_idle_x", curr_x, 3);
    do_start(1'b0, 1, 1, 0);
    follow(1'b0, 1, 1, 0, 50, -1);

    // Restart mid-scan while the consumer is also accepting.
    do_start(1'b0, 10, 10, 0);
    follow(1'b0, 10, 10, 0, 100, 37);
    pos_ready = 1'b1;
    do_start(1'b1, 4, 4, 0);
    follow(1'b1, 4, 4, 0, 70, -1);

    do_start(1'b1, 10, 10, 2);
    follow(1'b1, 10, 10, 2, 100, 12);
    rst = 1'b1;
    pos_ready = 1'b1;
    tick();
    check_zero("abort_reset");
    rst = 1'b0;
    pos_ready = 1'b0;
    tick();
    check_zero("abort_after");
    do_start(1'b0, 10, 10, 2);
    follow(1'b0, 10, 10, 2, 80, -1);

    do_start(1'b0, 8, 8, 1);
    follow(1'b0, 8, 8, 1, 100, 5);
    try_start(7, 5, 3);

    try_start(0, 5, 0);
    try_start(5, 0, 0);
    try_start(301, 5, 0);
    try_start(5, 301, 0);
    try_start(300, 300, 0);
    rst = 1'b1; tick(); rst = 1'b0;

    for (int t = 0; t < 12; t++) begin
      int mx, my, b, lim;
      bit md;
      md = 1'($urandom);
      mx = $urandom_range(1, 20);
      my = $urandom_range(1, 20);
      lim = ((mx < my ? mx : my) - 1) / 2;
      if (lim > 15) lim = 15;
      b = $urandom_range(0, lim);
      do_start(md, mx, my, b);
      follow(md, mx, my, b, $urandom_range(30, 100), -1);
    end

    for (int t = 0; t < 16; t++) begin
      try_start($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 15));
      rst = 1'b1; tick(); rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
